// File: rtl/epb_wb_bridge_sync.sv
// Single-clock EPB-to-Wishbone master bridge: one WB cycle per EPB chip-select, with bus-error reporting.
// Define EPB_WB_TIMEOUT_EN to abort WB cycles that receive no ack/err within TO_CYCLES clocks.
module epb_wb_bridge_sync #(
   parameter int DW        = 16,
   parameter int AW        = 23,
   parameter int GPW       = 6,
   parameter int GP_USED   = 3,
   parameter int TO_W      = 10,
   parameter int TO_CYCLES = 1000,
   parameter logic [DW-1:0] ERR_DATA = {(DW/16){16'hDEAD}}
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [DW/8-1:0]   wb_sel_o,
   output logic [31:0]       wb_adr_o,
   output logic [DW-1:0]     wb_dat_o,
   input  logic [DW-1:0]     wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i,
   input  logic              epb_cs_n,
   input  logic              epb_oe_n,
   input  logic              epb_r_w_n,
   input  logic [DW/8-1:0]   epb_be_n,
   input  logic [AW-1:0]     epb_addr,
   input  logic [GPW-1:0]    epb_addr_gp,
   input  logic [DW-1:0]     epb_data_i,
   output logic [DW-1:0]     epb_data_o,
   output logic              epb_data_oe_n,
   output logic              epb_rdy,
   output logic              trans_err_o,
   output logic [15:0]       err_cnt_o
);
   localparam int LSW = $clog2(DW/8);

   typedef enum logic [1:0] {IDLE, BUS, DONE, HOLD} state_t;
   state_t state, state_nxt;

   logic prev_cs_n;
   logic cs_rel;
   logic rd_hold;
   logic start;
   logic timed_out;
   logic wb_fin;
   logic wb_fail;
   logic unused_gp;

   assign unused_gp = ^epb_addr_gp;

`ifdef EPB_WB_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;

   assign timed_out = (to_cnt == TO_W'(TO_CYCLES - 1));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || state != BUS) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;
   end
`else
   logic unused_to;

   assign unused_to = (TO_CYCLES < (1 << TO_W));
   assign timed_out = 1'b0;
`endif

   assign start   = (state == IDLE) && prev_cs_n && !epb_cs_n;
   // An ack coinciding with err is reported as an error.
   assign wb_fail = (state == BUS) && (wb_err_i || timed_out);
   assign wb_fin  = (state == BUS) && (wb_ack_i || wb_err_i || timed_out);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      wb_cyc_o      = 1'b0;
      wb_stb_o      = 1'b0;
      epb_rdy       = 1'b0;
      epb_data_oe_n = ~(rd_hold & ~epb_oe_n);
      case (state)
         IDLE: if (start) state_nxt = BUS;
         BUS: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            if (wb_fin) state_nxt = DONE;
         end
         DONE: begin
            // A master that already dropped cs_n is not waiting for rdy.
            epb_rdy   = ~cs_rel;
            state_nxt = HOLD;
         end
         HOLD: if (epb_cs_n) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         prev_cs_n   <= 1'b0;
         cs_rel      <= 1'b0;
         rd_hold     <= 1'b0;
         trans_err_o <= 1'b0;
         err_cnt_o   <= '0;
         wb_we_o     <= 1'b0;
         wb_sel_o    <= '0;
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
         epb_data_o  <= '0;
      end else begin
         prev_cs_n   <= epb_cs_n;
         trans_err_o <= wb_fail;
         if (start) begin
            wb_adr_o <= 32'({epb_addr_gp[GP_USED-1:0], epb_addr, {LSW{1'b0}}});
            wb_sel_o <= ~epb_be_n;
            wb_we_o  <= ~epb_r_w_n;
            wb_dat_o <= epb_data_i;
            cs_rel   <= 1'b0;
         end
         if (state == BUS && epb_cs_n) cs_rel <= 1'b1;
         if (wb_fin) begin
            rd_hold <= ~wb_we_o;
            if (wb_fail) begin
               epb_data_o <= ERR_DATA;
               if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
            end else if (!wb_we_o) begin
               epb_data_o <= wb_dat_i;
            end
         end
         if (state == HOLD && epb_cs_n) rd_hold <= 1'b0;
      end
   end
endmodule

// File: tb/tb_epb_wb_bridge_sync.sv
// Directed bench for epb_wb_bridge_sync: a transaction-level model checks the DW=16 instance every cycle,
// and literal checks pin the model; a DW=32 instance covers the wide write.
module tb_epb_wb_bridge_sync;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DW=16 instance
   logic        cyc, stb, we, ack, err, cs_n, oe_n, r_w_n, eoe_n, rdy, terr;
   logic [1:0]  sel, be_n;
   logic [31:0] adr;
   logic [15:0] dato, dati, edi, edo, ecnt;
   logic [22:0] addr;
   logic [5:0]  gp;

   epb_wb_bridge_sync #(.DW(16)) u16 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
      .wb_sel_o(sel), .wb_adr_o(adr), .wb_dat_o(dato), .wb_dat_i(dati), .wb_ack_i(ack),
      .wb_err_i(err), .epb_cs_n(cs_n), .epb_oe_n(oe_n), .epb_r_w_n(r_w_n), .epb_be_n(be_n),
      .epb_addr(addr), .epb_addr_gp(gp), .epb_data_i(edi), .epb_data_o(edo),
      .epb_data_oe_n(eoe_n), .epb_rdy(rdy), .trans_err_o(terr), .err_cnt_o(ecnt));

   // DW=32 instance
   logic        cyc32, stb32, we32, ack32, err32, cs32, oe32, rw32, eoe32, rdy32, terr32;
   logic [3:0]  sel32, be32;
   logic [31:0] adr32, dato32, dati32, edi32, edo32;
   logic [15:0] ecnt32;
   logic [22:0] addr32;
   logic [5:0]  gp32;

   epb_wb_bridge_sync #(.DW(32)) u32 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_o(cyc32), .wb_stb_o(stb32), .wb_we_o(we32),
      .wb_sel_o(sel32), .wb_adr_o(adr32), .wb_dat_o(dato32), .wb_dat_i(dati32), .wb_ack_i(ack32),
      .wb_err_i(err32), .epb_cs_n(cs32), .epb_oe_n(oe32), .epb_r_w_n(rw32), .epb_be_n(be32),
      .epb_addr(addr32), .epb_addr_gp(gp32), .epb_data_i(edi32), .epb_data_o(edo32),
      .epb_data_oe_n(eoe32), .epb_rdy(rdy32), .trans_err_o(terr32), .err_cnt_o(ecnt32));

   int n_vec  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef EPB_WB_TIMEOUT_EN
   localparam int M_TO = 1000;
`else
   localparam int M_TO = 0;
`endif

   // Transaction-level model of the DW=16 instance
   logic        m_prev_cs, m_busy, m_pulse, m_wait, m_rel, m_rdhold, m_fail;
   int          m_age;
   logic        exp_we, exp_rdy, exp_terr;
   logic [1:0]  exp_sel;
   logic [31:0] exp_adr;
   logic [15:0] exp_dato, exp_data, exp_cnt;

   always @(posedge clk) begin
      if (rst) begin
         m_prev_cs = 0; m_busy = 0; m_pulse = 0; m_wait = 0; m_rel = 0; m_rdhold = 0;
         m_age = 0; exp_we = 0; exp_rdy = 0; exp_terr = 0; exp_sel = 0; exp_adr = 0;
         exp_dato = 0; exp_data = 0; exp_cnt = 0;
      end else begin
         exp_rdy  = 0;
         exp_terr = 0;
         if (m_pulse) begin
            m_pulse = 0;
            m_wait  = 1;
         end else if (m_wait) begin
            if (cs_n) begin
               m_wait   = 0;
               m_rdhold = 0;
            end
         end else if (m_busy) begin
            if (cs_n) m_rel = 1;
            m_age++;
            m_fail = err || (M_TO != 0 && m_age == M_TO);
            if (ack || m_fail) begin
               m_busy   = 0;
               m_pulse  = 1;
               exp_rdy  = !m_rel;
               m_rdhold = !exp_we;
               if (m_fail) begin
                  exp_data = 16'hDEAD;
                  exp_terr = 1;
                  if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1;
               end else if (!exp_we) begin
                  exp_data = dati;
               end
            end
         end else if (m_prev_cs && !cs_n) begin
            m_busy   = 1;
            m_age    = 0;
            m_rel    = 0;
            exp_adr  = (32'(gp[2:0]) << 24) | (32'(addr) << 1);
            exp_sel  = ~be_n;
            exp_we   = !r_w_n;
            exp_dato = edi;
         end
         m_prev_cs = cs_n;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc", {31'd0, cyc}, {31'd0, m_busy});
         check("stb", {31'd0, stb}, {31'd0, m_busy});
         check("we", {31'd0, we}, {31'd0, exp_we});
         check("sel", {30'd0, sel}, {30'd0, exp_sel});
         check("adr", adr, exp_adr);
         check("wb_dat_o", {16'd0, dato}, {16'd0, exp_dato});
         check("epb_data_o", {16'd0, edo}, {16'd0, exp_data});
         check("epb_data_oe_n", {31'd0, eoe_n}, {31'd0, !(m_rdhold && !oe_n)});
         check("epb_rdy", {31'd0, rdy}, {31'd0, exp_rdy});
         check("trans_err", {31'd0, terr}, {31'd0, exp_terr});
         check("err_cnt", {16'd0, ecnt}, {16'd0, exp_cnt});
      end
   end

   int   rdy_cnt = 0, rdy32_cnt = 0, cyc_rise = 0;
   logic cyc_q = 1'b0;
   always @(negedge clk) begin
      if (rdy === 1'b1) rdy_cnt++;
      if (rdy32 === 1'b1) rdy32_cnt++;
      if (cyc === 1'b1 && cyc_q !== 1'b1) cyc_rise++;
      cyc_q = cyc;
   end

   task automatic wait_cyc(input int budget);
      int n = 0;
      while (cyc !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check("cyc_start", {31'd0, cyc}, 32'd1);
   endtask

   task automatic start16(input logic [22:0] a, input logic [5:0] g, input logic [1:0] b,
                          input logic rw, input logic [15:0] d);
      addr = a; gp = g; be_n = b; r_w_n = rw; edi = d; cs_n = 1'b0;
   endtask

   task automatic release16();
      repeat (3) tick();
      cs_n = 1'b1; oe_n = 1'b1;
      repeat (2) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n, rd0, cr0;
      rst = 1; cs_n = 1; oe_n = 1; r_w_n = 1; be_n = 2'b11; addr = 0; gp = 0; edi = 0;
      dati = 0; ack = 0; err = 0;
      cs32 = 1; oe32 = 1; rw32 = 1; be32 = 4'hF; addr32 = 0; gp32 = 0; edi32 = 0;
      dati32 = 0; ack32 = 0; err32 = 0;
      tick();
      chk_en = 1;
      tick();
      check("rst_cyc", {31'd0, cyc}, 32'd0);
      check("rst_oe_n", {31'd0, eoe_n}, 32'd1);
      check("rst_err_cnt", {16'd0, ecnt}, 32'd0);
      rst = 0;
      repeat (2) tick();

      // Read with ack after three cycles
      rdy_cnt = 0;
      oe_n = 0;
      start16(23'h000123, 6'h05, 2'b00, 1'b1, 16'h0000);
      wait_cyc(20);
      check("rd_adr", adr, 32'h0500_0246);
      check("rd_sel", {30'd0, sel}, 32'd3);
      check("rd_we", {31'd0, we}, 32'd0);
      repeat (2) tick();
      dati = 16'hBEEF; ack = 1;
      tick();
      ack = 0; dati = 0;
      check("rd_rdy", {31'd0, rdy}, 32'd1);
      check("rd_data", {16'd0, edo}, 32'h0000_BEEF);
      check("rd_oe_low", {31'd0, eoe_n}, 32'd0);
      tick();
      oe_n = 1;
      #1 check("rd_oe_gated", {31'd0, eoe_n}, 32'd1);
      oe_n = 0;
      release16();
      check("rd_oe_after_cs", {31'd0, eoe_n}, 32'd1);
      check("rd_rdy_count", rdy_cnt, 32'd1);

      // Bus error on a read, with boundary address and upper gp bits dropped
      start16(23'h7FFFFF, 6'h3F, 2'b10, 1'b1, 16'h0000);
      wait_cyc(20);
      check("err_adr", adr, 32'h07FF_FFFE);
      check("err_sel", {30'd0, sel}, 32'd1);
      tick();
      err = 1; dati = 16'h1111;
      tick();
      err = 0; dati = 0;
      check("err_data", {16'd0, edo}, 32'h0000_DEAD);
      check("err_pulse", {31'd0, terr}, 32'd1);
      check("err_cnt1", {16'd0, ecnt}, 32'd1);
      check("err_rdy", {31'd0, rdy}, 32'd1);
      release16();

      // Write with ack and err together, oe_n held low
      oe_n = 0;
      start16(23'h000040, 6'h00, 2'b01, 1'b0, 16'hA5A5);
      wait_cyc(20);
      check("wr_dat", {16'd0, dato}, 32'h0000_A5A5);
      check("wr_sel", {30'd0, sel}, 32'd2);
      check("wr_we", {31'd0, we}, 32'd1);
      ack = 1; err = 1;
      tick();
      ack = 0; err = 0;
      check("ackerr_cnt", {16'd0, ecnt}, 32'd2);
      check("ackerr_oe", {31'd0, eoe_n}, 32'd1);
      release16();

      // No response: timeout abort, or indefinite wait without it
      rdy_cnt = 0;
      start16(23'h000200, 6'h01, 2'b00, 1'b1, 16'h0000);
      wait_cyc(20);
`ifdef EPB_WB_TIMEOUT_EN
      n = 1;
      while (cyc === 1'b1 && n < 1100) begin
         tick();
         if (cyc === 1'b1) n++;
      end
      check("to_len", n, 32'd1000);
      check("to_cnt", {16'd0, ecnt}, 32'd3);
      check("to_rdy", {31'd0, rdy}, 32'd1);
`else
      repeat (5000) tick();
      check("noto_cyc", {31'd0, cyc}, 32'd1);
      dati = 16'h0F0F; ack = 1;
      tick();
      ack = 0; dati = 0;
      check("noto_data", {16'd0, edo}, 32'h0000_0F0F);
`endif
      release16();
      check("to_rdy_count", rdy_cnt, 32'd1);

      // cs_n released, then dropped again, during BUS
      rdy_cnt = 0; cr0 = cyc_rise;
      start16(23'h000300, 6'h02, 2'b00, 1'b1, 16'h0000);
      wait_cyc(20);
      tick();
      cs_n = 1;
      repeat (2) tick();
      cs_n = 0;
      tick();
      dati = 16'h2222; ack = 1;
      tick();
      ack = 0; dati = 0;
      check("rel_no_rdy", {31'd0, rdy}, 32'd0);
      repeat (5) tick();
      check("rel_one_cycle", cyc_rise - cr0, 32'd1);
      cs_n = 1;
      repeat (2) tick();
      cs_n = 0;
      wait_cyc(20);
      tick();
      ack = 1;
      tick();
      ack = 0;
      release16();
      check("rel_rdy_count", rdy_cnt, 32'd1);

      // Reset during BUS with cs_n held low
      start16(23'h000400, 6'h03, 2'b00, 1'b0, 16'h5555);
      wait_cyc(20);
      tick();
      rst = 1;
      tick();
      check("rrst_cyc", {31'd0, cyc}, 32'd0);
      check("rrst_adr", adr, 32'd0);
      check("rrst_cnt", {16'd0, ecnt}, 32'd0);
      rst = 0;
      cr0 = cyc_rise;
      repeat (5) tick();
      check("rrst_no_restart", cyc_rise - cr0, 32'd0);
      cs_n = 1;
      repeat (2) tick();
      cs_n = 0;
      wait_cyc(20);
      ack = 1;
      tick();
      ack = 0;
      release16();

      // 32-bit write
      rd0 = rdy32_cnt;
      addr32 = 23'h000010; gp32 = 6'h00; be32 = 4'b1100; rw32 = 0; edi32 = 32'h1234_5678;
      oe32 = 0; cs32 = 0;
      n = 0;
      while (cyc32 !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("w32_cyc", {31'd0, cyc32}, 32'd1);
      check("w32_dat", dato32, 32'h1234_5678);
      check("w32_sel", {28'd0, sel32}, 32'd3);
      check("w32_we", {31'd0, we32}, 32'd1);
      check("w32_adr", adr32, 32'h0000_0040);
      ack32 = 1;
      tick();
      ack32 = 0;
      check("w32_rdy", {31'd0, rdy32}, 32'd1);
      check("w32_oe", {31'd0, eoe32}, 32'd1);
      tick();
      check("w32_oe_hold", {31'd0, eoe32}, 32'd1);
      cs32 = 1; oe32 = 1;
      repeat (2) tick();
      check("w32_rdy_count", rdy32_cnt - rd0, 32'd1);

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
